ptp_ts_capture_array: RTL and testbench
=======================================

// Module: ptp_ts_capture_array
// PURPOSE
//  Multi-channel PTP event timestamp capture, generalising the single RX/TX TSU queue pair
//  to NUM_CH channels, each with its own queue. Every qualifying event on ev_in[i] stores the
//  current 80-bit RTC time {sec[47:0],ns[31:0]} plus a 16-bit per-channel sequence number.
//  Entries are pulled by the host over the standard 32-bit word register bus.
//  Sits beside rtc in the rtc_clk domain; ev_in and the bus are already synchronous to clk.
// PARAMETERS
//  NUM_CH     4   number of capture channels, 1..8
//  DEPTH_LOG2 4   per-channel queue depth = 2**DEPTH_LOG2 entries (96 bits each)
//  EDGE_MODE  1   1: capture on rising edge of ev_in[i]; 0: capture every cycle ev_in[i]=1
// PORTS
//  clk          in   1       single clock (rtc_clk domain)
//  rst          in   1       asynchronous reset, active-low
//  wr_in        in   1       register write strobe, 1 cycle
//  rd_in        in   1       register read strobe, 1 cycle
//  addr_in      in   8       byte address; [1:0] ignored
//  data_in      in   32      write data
//  data_out     out  32      read data, registered
//  ev_in        in   NUM_CH  event inputs
//  rtc_ns_in    in   32      current RTC nanoseconds
//  rtc_sec_in   in   48      current RTC seconds
//  irq_out      out  1       level: OR over i of (nonempty[i] & irq_en[i])
// BEHAVIOUR
//  Reset (rst=0): all queue pointers, levels, seq counters and sticky flags = 0; holding regs = 0;
//   data_out = 0; irq_out = 0; CTRL = 0 (all channels disabled). Edge-detect history regs = 0.
//  Register map (word offsets). Unmapped addresses read 0 and ignore writes.
//   0x00 CTRL  RW [7:0] ch_en, [15:8] irq_en, [31] clear (write 1: flush all queues, seq, sticky; self-clears)
//   0x04 STAT  RO [7:0] nonempty, [15:8] overflow sticky, [23:16] full
//   0x08 OVFC  W1C [15:8] clear overflow sticky; reads same as STAT[15:8]
//   0x0C SEL   RW [2:0] channel select (values >= NUM_CH read back as written, pops ignored)
//   0x10 POP   WO any write pops head of SEL channel into holding regs
//   0x14 HSECH RO holding sec[47:32] in [15:0]; holding seq in [31:16]
//   0x18 HSECL RO holding sec[31:0]
//   0x1C HNS   RO holding ns[31:0]
//   0x20 LVL   RO [DEPTH_LOG2:0] fill level of SEL channel; [31] holding_valid
//  Bits for channels >= NUM_CH are reserved and read 0.
//  Capture: event qualifies when ch_en[i]=1 and (EDGE_MODE ? ev_in[i] & ~ev_d[i] : ev_in[i]).
//   The stored time is the rtc value sampled in the same cycle as the qualifying event.
//   Entry is visible (nonempty, level) 1 cycle later. seq[i] increments per accepted entry and wraps 0xFFFF->0.
//  Full: a qualifying event is dropped; overflow[i] is set and seq[i] still increments.
//   The seq gap therefore marks the loss.
//  Pop: a POP write on an empty channel leaves the holding regs unchanged and clears holding_valid.
//   A POP write on a nonempty channel loads the holding regs on the next cycle and sets holding_valid.
//  Simultaneous capture + pop on the same channel:
//   - pop of the old head and push both occur; the level is unchanged.
//   - if the channel was full, the push is accepted (pop frees the slot) and no overflow is raised.
//  Clear coinciding with a capture: clear wins and the event is discarded.
//   A pop in the same cycle is ignored and holding_valid = 0.
//  Read: data_out is updated 1 cycle after rd_in; otherwise it holds its last value.
//   Reads have no side effects.
//  Reset mid-operation: all contents are lost asynchronously; no partial entry survives.
// TESTING
//  1 Reset: rst low then high -> STAT=0, data_out=0, irq_out=0, LVL of ch0=0.
//  2 Capture: CTRL=0x01, sec=0x000000000005, ns=0x1234_5678, pulse ev_in[0], SEL=0, POP
//    -> HSECL=5, HNS=0x12345678, HSECH seq=0, LVL[31]=1.
//  3 Edge: EDGE_MODE=1, ev_in[1] held high 10 cycles -> exactly 1 entry.
//    EDGE_MODE=0 with the same stimulus -> 10 entries.
//  4 Overflow: DEPTH=16, 17 edges on ch2 -> STAT full[2]=1 and ovf[2]=1.
//    Popping all 16 yields seq 0..15; next capture has seq 17. OVFC write 0x400 clears ovf[2].
//  5 Full + pop + capture in the same cycle on ch3 -> level stays 16, STAT ovf[3]=0.
//  6 IRQ/clear: CTRL=0x0101, capture ch0 -> irq_out=1. Write CTRL bit31 -> all levels 0, irq_out=0,
//    next seq=0. POP on empty -> LVL[31]=0.

Source files
------------

// File: rtl/ptp_ts_capture_array.sv
// Multi-channel PTP event timestamp capture: one 96-bit {seq, sec, ns} queue per channel,
// drained by the host through a 32-bit word register bus.
module ptp_ts_capture_array #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter bit          EDGE_MODE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_in,
  input  logic              rd_in,
  input  logic [7:0]        addr_in,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic [NUM_CH-1:0] ev_in,
  input  logic [31:0]       rtc_ns_in,
  input  logic [47:0]       rtc_sec_in,
  output logic              irq_out
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [LW-1:0]         lvl_t;

  localparam logic [5:0] WCtrl  = 6'd0;
  localparam logic [5:0] WStat  = 6'd1;
  localparam logic [5:0] WOvfc  = 6'd2;
  localparam logic [5:0] WSel   = 6'd3;
  localparam logic [5:0] WPop   = 6'd4;
  localparam logic [5:0] WHsech = 6'd5;
  localparam logic [5:0] WHsecl = 6'd6;
  localparam logic [5:0] WHns   = 6'd7;
  localparam logic [5:0] WLvl   = 6'd8;

  logic [NUM_CH-1:0] ch_en_q, irq_en_q, ev_d_q, ovf_q;
  logic [2:0]        sel_q;
  ptr_t              wr_ptr_q [NUM_CH];
  ptr_t              rd_ptr_q [NUM_CH];
  lvl_t              level_q  [NUM_CH];
  logic [15:0]       seq_q    [NUM_CH];
  logic [95:0]       mem_q    [NUM_CH][DEPTH];
  logic [95:0]       hold_q;
  logic              hvalid_q;

  logic [5:0]  word;
  logic        wr_ctrl, wr_ovfc, wr_sel, wr_pop, clear, sel_ok, pop_any;
  logic [31:0] rdata;
  logic [95:0] head;
  lvl_t        sel_level;
  logic [NUM_CH-1:0] nonempty, full, qual, do_pop, push, ovf_set;
  logic        unused_bits;

  assign word    = addr_in[7:2];
  assign wr_ctrl = wr_in & (word == WCtrl);
  assign wr_ovfc = wr_in & (word == WOvfc);
  assign wr_sel  = wr_in & (word == WSel);
  assign wr_pop  = wr_in & (word == WPop);
  assign clear   = wr_ctrl & data_in[31];
  assign sel_ok  = 32'(sel_q) < NUM_CH;
  // Pops on an out-of-range channel are ignored entirely, holding state included.
  assign pop_any = wr_pop & sel_ok & ~clear;
  assign irq_out = |(nonempty & irq_en_q);
  assign unused_bits = ^{addr_in[1:0], data_in};

  always_comb begin
    nonempty  = '0;
    full      = '0;
    qual      = '0;
    do_pop    = '0;
    push      = '0;
    ovf_set   = '0;
    head      = '0;
    sel_level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nonempty[i] = level_q[i] != '0;
      full[i]     = level_q[i] == lvl_t'(DEPTH);
      qual[i]     = ch_en_q[i] & (EDGE_MODE ? (ev_in[i] & ~ev_d_q[i]) : ev_in[i]);
      do_pop[i]   = pop_any & (sel_q == 3'(i)) & nonempty[i];
      // A same-cycle pop frees the slot, so a full channel still accepts the push.
      push[i]     = qual[i] & ~clear & (~full[i] | do_pop[i]);
      ovf_set[i]  = qual[i] & ~clear & full[i] & ~do_pop[i];
      if (sel_q == 3'(i)) begin
        head      = mem_q[i][rd_ptr_q[i]];
        sel_level = level_q[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      WCtrl: begin
        rdata[NUM_CH-1:0]  = ch_en_q;
        rdata[8 +: NUM_CH] = irq_en_q;
      end
      WStat: begin
        rdata[NUM_CH-1:0]   = nonempty;
        rdata[8 +: NUM_CH]  = ovf_q;
        rdata[16 +: NUM_CH] = full;
      end
      WOvfc:  rdata[8 +: NUM_CH] = ovf_q;
      WSel:   rdata[2:0] = sel_q;
      WHsech: rdata = {hold_q[95:80], hold_q[79:64]};
      WHsecl: rdata = hold_q[63:32];
      WHns:   rdata = hold_q[31:0];
      WLvl: begin
        rdata[LW-1:0] = sel_level;
        rdata[31]     = hvalid_q;
      end
      default: rdata = '0;
    endcase
  end

  // Entry storage needs no reset: pointers and levels define which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {seq_q[i], rtc_sec_in, rtc_ns_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_en_q  <= '0;
      irq_en_q <= '0;
      ev_d_q   <= '0;
      ovf_q    <= '0;
      sel_q    <= '0;
      hold_q   <= '0;
      hvalid_q <= 1'b0;
      data_out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        level_q[i]  <= '0;
        seq_q[i]    <= '0;
      end
    end else begin
      ev_d_q <= ev_in;
      if (wr_ctrl) begin
        ch_en_q  <= data_in[NUM_CH-1:0];
        irq_en_q <= data_in[8 +: NUM_CH];
      end
      if (wr_sel) sel_q <= data_in[2:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
          level_q[i]  <= '0;
          seq_q[i]    <= '0;
          ovf_q[i]    <= 1'b0;
        end else begin
          if (push[i])   wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (do_pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
          if (push[i] && !do_pop[i])      level_q[i] <= level_q[i] + 1'b1;
          else if (!push[i] && do_pop[i]) level_q[i] <= level_q[i] - 1'b1;
          // Dropped events still advance seq so the host sees the gap.
          if (qual[i]) seq_q[i] <= seq_q[i] + 16'd1;
          if (ovf_set[i])                        ovf_q[i] <= 1'b1;
          else if (wr_ovfc && data_in[8 + i])    ovf_q[i] <= 1'b0;
        end
      end
      if (clear) begin
        hvalid_q <= 1'b0;
      end else if (pop_any) begin
        if (|do_pop) begin
          hold_q   <= head;
          hvalid_q <= 1'b1;
        end else begin
          hvalid_q <= 1'b0;
        end
      end
      if (rd_in) data_out <= rdata;
    end
  end

endmodule

// File: tb/tb_ptp_ts_capture_array.sv
// Bench for ptp_ts_capture_array: edge and level instances share stimulus; a queue-based model
// predicts each read, and a monitor compares when read data appears.
module tb_ptp_ts_capture_array;

  localparam int NCH = 4;
  localparam int DL2 = 4;
  localparam int DEP = 16;

  localparam bit [7:0] ACtrl = 8'h00, AStat = 8'h04, AOvfc = 8'h08, ASel = 8'h0C, APop = 8'h10;
  localparam bit [7:0] AHsech = 8'h14, AHsecl = 8'h18, AHns = 8'h1C, ALvl = 8'h20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_in = 1'b0, rd_in = 1'b0;
  logic [7:0]      addr_in = '0;
  logic [31:0]     data_in = '0;
  logic [NCH-1:0]  ev_in = '0;
  logic [31:0]     rtc_ns_in = '0;
  logic [47:0]     rtc_sec_in = '0;
  logic [31:0]     dout0, dout1;
  logic            irq0, irq1;

  always #5 clk = ~clk;

  ptp_ts_capture_array #(.NUM_CH(NCH), .DEPTH_LOG2(DL2), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .rst(rst), .wr_in(wr_in), .rd_in(rd_in), .addr_in(addr_in), .data_in(data_in),
    .data_out(dout0), .ev_in(ev_in), .rtc_ns_in(rtc_ns_in), .rtc_sec_in(rtc_sec_in),
    .irq_out(irq0)
  );

  ptp_ts_capture_array #(.NUM_CH(NCH), .DEPTH_LOG2(DL2), .EDGE_MODE(1'b0)) u_level (
    .clk(clk), .rst(rst), .wr_in(wr_in), .rd_in(rd_in), .addr_in(addr_in), .data_in(data_in),
    .data_out(dout1), .ev_in(ev_in), .rtc_ns_in(rtc_ns_in), .rtc_sec_in(rtc_sec_in),
    .irq_out(irq1)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit [31:0] exp0_q [$];
  bit [31:0] exp1_q [$];
  string     nm_q [$];
  bit        rd_seen = 1'b0;

  // Reference model, index 0 = edge instance, 1 = level instance.
  bit [95:0]      mq [2][NCH][$];
  bit [15:0]      mseq [2][NCH];
  bit [NCH-1:0]   movf [2], men [2], mien [2], mprev [2];
  bit [2:0]       msel [2];
  bit [95:0]      mhold [2];
  bit             mhv [2];

  bit [NCH-1:0]   ev_cur = '0;
  bit [47:0]      sec_v = '0;
  bit [31:0]      ns_v = '0;

  task automatic check(input string nm, input logic [31:0] act, input bit [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NCH; i++) begin
        mq[m][i].delete();
        mseq[m][i] = '0;
      end
      movf[m] = '0; men[m] = '0; mien[m] = '0; mprev[m] = '0;
      msel[m] = '0; mhold[m] = '0; mhv[m] = 1'b0;
    end
  endfunction

  function automatic bit model_irq(input int m);
    bit r = 1'b0;
    for (int i = 0; i < NCH; i++) if (mq[m][i].size() > 0 && mien[m][i]) r = 1'b1;
    return r;
  endfunction

  function automatic bit [31:0] model_read(input int m, input bit [7:0] a);
    bit [31:0] r = '0;
    int wd = int'(a[7:2]);
    int s = int'(msel[m]);
    case (wd)
      0: begin r[NCH-1:0] = men[m]; r[8 +: NCH] = mien[m]; end
      1: for (int i = 0; i < NCH; i++) begin
           r[i]      = mq[m][i].size() > 0;
           r[8 + i]  = movf[m][i];
           r[16 + i] = mq[m][i].size() == DEP;
         end
      2: r[8 +: NCH] = movf[m];
      3: r[2:0] = msel[m];
      5: r = {mhold[m][95:80], mhold[m][79:64]};
      6: r = mhold[m][63:32];
      7: r = mhold[m][31:0];
      8: begin
           r[31] = mhv[m];
           if (s < NCH) r[DL2:0] = (DL2 + 1)'(mq[m][s].size());
         end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void model_step(input int m, input bit w, input bit [7:0] a,
                                     input bit [31:0] d, input bit [NCH-1:0] e,
                                     input bit [47:0] s, input bit [31:0] n);
    int wd = int'(a[7:2]);
    int sl = int'(msel[m]);
    bit clr = w && wd == 0 && d[31];
    bit [NCH-1:0] q;
    for (int i = 0; i < NCH; i++) q[i] = men[m][i] && (m == 0 ? (e[i] && !mprev[m][i]) : e[i]);
    mprev[m] = e;
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        mq[m][i].delete();
        mseq[m][i] = '0;
      end
      movf[m] = '0;
      mhv[m] = 1'b0;
    end else begin
      if (w && wd == 4 && sl < NCH) begin
        if (mq[m][sl].size() > 0) begin
          mhold[m] = mq[m][sl].pop_front();
          mhv[m] = 1'b1;
        end else begin
          mhv[m] = 1'b0;
        end
      end
      if (w && wd == 2) movf[m] &= ~d[8 +: NCH];
      for (int i = 0; i < NCH; i++) begin
        if (q[i]) begin
          if (mq[m][i].size() < DEP) mq[m][i].push_back({mseq[m][i], s, n});
          else movf[m][i] = 1'b1;
          mseq[m][i] = mseq[m][i] + 16'd1;
        end
      end
    end
    if (w && wd == 0) begin
      men[m] = d[NCH-1:0];
      mien[m] = d[8 +: NCH];
    end
    if (w && wd == 3) msel[m] = d[2:0];
  endfunction

  // One bus cycle; expected read data is queued when the read is issued.
  task automatic cyc(input bit w, input bit r, input bit [7:0] a, input bit [31:0] d,
                     input string nm = "rd", input bit use_c = 1'b0,
                     input bit [31:0] c0 = '0, input bit [31:0] c1 = '0);
    @(negedge clk);
    check("irq_edge", {31'b0, irq0}, {31'b0, model_irq(0)});
    check("irq_level", {31'b0, irq1}, {31'b0, model_irq(1)});
    wr_in = w; rd_in = r; addr_in = a; data_in = d;
    ev_in = ev_cur; rtc_sec_in = sec_v; rtc_ns_in = ns_v;
    if (r) begin
      nm_q.push_back(nm);
      exp0_q.push_back(use_c ? c0 : model_read(0, a));
      exp1_q.push_back(use_c ? c1 : model_read(1, a));
    end
    for (int m = 0; m < 2; m++) model_step(m, w, a, d, ev_cur, sec_v, ns_v);
    ns_v += 32'd7;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, '0);
  endtask

  task automatic wr_reg(input bit [7:0] a, input bit [31:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic rdc(input bit [7:0] a, input string nm, input bit [31:0] c0, input bit [31:0] c1);
    cyc(1'b0, 1'b1, a, '0, nm, 1'b1, c0, c1);
  endtask

  task automatic pulse(input int ch);
    ev_cur = NCH'(1 << ch);
    idle();
    ev_cur = '0;
    idle();
  endtask

  task automatic mid_reset();
    ev_cur = '0;
    idle();
    idle();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dout_edge", dout0, 32'h0);
    check("async_rst_dout_level", dout1, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) rd_seen <= rd_in;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (nm_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL read_without_expectation: got 0x%08h, expected none", dout0);
      end else begin
        string nm;
        nm = nm_q.pop_front();
        check({nm, "_edge"}, dout0, exp0_q.pop_front());
        check({nm, "_level"}, dout1, exp1_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout", dout0, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);
    rst = 1'b1;
    rdc(AStat, "t1_stat", 32'h0, 32'h0);
    rdc(ALvl, "t1_lvl", 32'h0, 32'h0);

    wr_reg(ACtrl, 32'h1);
    sec_v = 48'h5;
    ns_v = 32'h1234_5678;
    pulse(0);
    wr_reg(ASel, 32'h0);
    wr_reg(APop, 32'h0);
    rdc(AHsecl, "t2_hsecl", 32'h5, 32'h5);
    rdc(AHns, "t2_hns", 32'h1234_5678, 32'h1234_5678);
    rdc(AHsech, "t2_hsech", 32'h0, 32'h0);
    rdc(ALvl, "t2_lvl", 32'h8000_0000, 32'h8000_0000);

    wr_reg(ACtrl, 32'h8000_0002);
    ev_cur = 4'b0010;
    repeat (10) idle();
    ev_cur = '0;
    wr_reg(ASel, 32'h1);
    rdc(ALvl, "t3_lvl", 32'h1, 32'hA);

    wr_reg(ACtrl, 32'h8000_0004);
    repeat (17) pulse(2);
    rdc(AStat, "t4_stat_full", 32'h0004_0404, 32'h0004_0404);
    wr_reg(ASel, 32'h2);
    for (int i = 0; i < 16; i++) begin
      wr_reg(APop, 32'h0);
      rdc(AHsech, "t4_seq", 32'(i) << 16, 32'(i) << 16);
    end
    pulse(2);
    wr_reg(APop, 32'h0);
    rdc(AHsech, "t4_seq_gap", 32'd17 << 16, 32'd17 << 16);
    rdc(AStat, "t4_stat_ovf", 32'h400, 32'h400);
    wr_reg(AOvfc, 32'h400);
    rdc(AStat, "t4_stat_w1c", 32'h0, 32'h0);

    wr_reg(ACtrl, 32'h8000_0008);
    repeat (16) pulse(3);
    wr_reg(ASel, 32'h3);
    ev_cur = 4'b1000;
    cyc(1'b1, 1'b0, APop, '0);
    ev_cur = '0;
    rdc(ALvl, "t5_lvl", 32'h8000_0010, 32'h8000_0010);
    rdc(AStat, "t5_stat", 32'h0008_0008, 32'h0008_0008);

    wr_reg(ACtrl, 32'h8000_0101);
    wr_reg(ASel, 32'h0);
    pulse(0);
    check("t6_irq_set", {31'b0, irq0}, 32'h1);
    wr_reg(ACtrl, 32'h8000_0101);
    idle();
    check("t6_irq_clr", {31'b0, irq0}, 32'h0);
    rdc(ALvl, "t6_lvl_clr", 32'h0, 32'h0);
    pulse(0);
    wr_reg(APop, 32'h0);
    rdc(AHsech, "t6_seq0", 32'h0, 32'h0);
    wr_reg(APop, 32'h0);
    rdc(ALvl, "t6_pop_empty", 32'h0, 32'h0);

    for (int it = 0; it < 3000; it++) begin
      bit w, r;
      bit [5:0] wd;
      bit [31:0] d;
      if (it == 1500) mid_reset();
      ev_cur = NCH'($urandom);
      sec_v = {16'($urandom), 32'($urandom)};
      ns_v = $urandom;
      w = $urandom_range(0, 9) < 3;
      r = $urandom_range(0, 9) < 4;
      wd = 6'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) wd = 6'd4;
      d = $urandom;
      if (wd == 6'd0) d[31] = ($urandom_range(0, 60) == 0);
      cyc(w, r, {wd, 2'($urandom)}, d, "rnd");
    end

    ev_cur = '0;
    repeat (3) idle();
    check("drain", 32'(nm_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
